lsu_mem_ctrl: RTL and testbench

Load/store unit controller that sits between the CPU pipeline's memory stage and the byte-banked data memory. It accepts one load or store request at a time over a valid/ready handshake and drives the data memory port (`memAddr`, `memRead`, `memWrite`, `memDataIn`, `memType`). It holds that port stable for the full read latency and captures the sign- or zero-extended `memDataOut`. It rejects misaligned, illegal-type and out-of-range accesses without touching memory, and returns the result or error over a valid/ready response channel.

---
 rtl/lsu_mem_ctrl_if.sv | 38 +++
 rtl/lsu_mem_ctrl.sv | 179 +++++++++++++++++
 tb/tb_lsu_mem_ctrl.sv | 434 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/lsu_mem_ctrl_if.sv
// Pipeline request/response channels and the byte-banked data-memory port,
// bundled so the LSU controller, the pipeline and the memory share one view.
interface lsu_mem_ctrl_if #(
  parameter int ADDR_W = 15
);
  logic              req_valid;
  logic              req_ready;
  logic              req_store;
  logic [2:0]        req_type;
  logic [31:0]       req_addr;
  logic [31:0]       req_wdata;

  logic              rsp_valid;
  logic              rsp_ready;
  logic [31:0]       rsp_data;
  logic              rsp_err;

  logic [ADDR_W-1:0] memAddr;
  logic              memRead;
  logic              memWrite;
  logic [31:0]       memDataIn;
  logic [2:0]        memType;
  logic [31:0]       memDataOut;

  // Pipeline and memory side: issues requests, takes responses, returns read data.
  modport master (
    output req_valid, req_store, req_type, req_addr, req_wdata, rsp_ready, memDataOut,
    input  req_ready, rsp_valid, rsp_data, rsp_err,
    input  memAddr, memRead, memWrite, memDataIn, memType
  );

  // Controller side.
  modport slave (
    input  req_valid, req_store, req_type, req_addr, req_wdata, rsp_ready, memDataOut,
    output req_ready, rsp_valid, rsp_data, rsp_err,
    output memAddr, memRead, memWrite, memDataIn, memType
  );
endinterface

// File: rtl/lsu_mem_ctrl.sv
// Single-outstanding load/store controller: validates a request, drives the data
// memory port for one write cycle or READ_LATENCY+1 read cycles, returns a response.
module lsu_mem_ctrl #(
  parameter int ADDR_W       = 15,
  parameter int READ_LATENCY = 1
) (
  input logic           clk,
  input logic           rst,
  lsu_mem_ctrl_if.slave bus
);

  localparam int CNT_W = (READ_LATENCY < 1) ? 1 : $clog2(READ_LATENCY + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(READ_LATENCY);
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1'b1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_READ  = 2'd2,
    ST_RESP  = 2'd3
  } state_t;

  // Any reason the access must be refused before memory is touched.
  function automatic logic access_err(input logic       store,
                                      input logic [2:0]  typ,
                                      input logic [31:0] addr);
    logic bad_type;
    logic misaligned;
    logic out_of_range;
    case (typ)
      3'b000: begin bad_type = 1'b0;  misaligned = 1'b0;               end
      3'b001: begin bad_type = 1'b0;  misaligned = addr[0];            end
      3'b010: begin bad_type = 1'b0;  misaligned = (addr[1:0] != 2'b00); end
      3'b100: begin bad_type = store; misaligned = 1'b0;               end
      3'b101: begin bad_type = store; misaligned = addr[0];            end
      default: begin bad_type = 1'b1; misaligned = 1'b0;               end
    endcase
    out_of_range = ((addr >> ADDR_W) != 32'd0);
    return bad_type | misaligned | out_of_range;
  endfunction

  state_t            state_r;
  state_t            next_state_s;
  logic [CNT_W-1:0]  cnt_r;
  logic              accept_s;
  logic              err_s;

  logic              req_ready_s;
  logic              rsp_valid_s;
  logic              mem_read_s;
  logic              mem_write_s;

  logic              req_ready_r;
  logic              rsp_valid_r;
  logic              mem_read_r;
  logic              mem_write_r;

  logic [ADDR_W-1:0] mem_addr_r;
  logic [2:0]        mem_type_r;
  logic [31:0]       mem_wdata_r;
  logic [31:0]       rsp_data_r;
  logic              rsp_err_r;

  // The handshake uses the registered ready, so acceptance matches what the pipeline sees.
  assign accept_s = bus.req_valid & req_ready_r;
  assign err_s    = access_err(bus.req_store, bus.req_type, bus.req_addr);

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state decode.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) begin
          if (err_s) begin
            next_state_s = ST_RESP;
          end else if (bus.req_store) begin
            next_state_s = ST_WRITE;
          end else begin
            next_state_s = ST_READ;
          end
        end else begin
          next_state_s = ST_IDLE;
        end
      end
      ST_WRITE: next_state_s = ST_RESP;
      ST_READ: begin
        if (cnt_r == CNT_ZERO) begin
          next_state_s = ST_RESP;
        end else begin
          next_state_s = ST_READ;
        end
      end
      ST_RESP: begin
        if (bus.rsp_ready) begin
          next_state_s = ST_IDLE;
        end else begin
          next_state_s = ST_RESP;
        end
      end
      default: next_state_s = ST_IDLE;
    endcase
  end

  // Output decode from the upcoming state; registered below so strobes come straight off flops.
  always_comb begin
    req_ready_s = 1'b0;
    rsp_valid_s = 1'b0;
    mem_read_s  = 1'b0;
    mem_write_s = 1'b0;
    case (next_state_s)
      ST_IDLE:  req_ready_s = 1'b1;
      ST_WRITE: mem_write_s = 1'b1;
      ST_READ:  mem_read_s  = 1'b1;
      ST_RESP:  rsp_valid_s = 1'b1;
      default:  req_ready_s = 1'b0;
    endcase
  end

  // Control output registers; reset drops every strobe asynchronously.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      req_ready_r <= 1'b0;
      rsp_valid_r <= 1'b0;
      mem_read_r  <= 1'b0;
      mem_write_r <= 1'b0;
    end else begin
      req_ready_r <= req_ready_s;
      rsp_valid_r <= rsp_valid_s;
      mem_read_r  <= mem_read_s;
      mem_write_r <= mem_write_s;
    end
  end

  // Memory port and response datapath; port fields only change on accept.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_addr_r  <= {ADDR_W{1'b0}};
      mem_type_r  <= 3'b000;
      mem_wdata_r <= 32'd0;
      cnt_r       <= CNT_ZERO;
      rsp_data_r  <= 32'd0;
      rsp_err_r   <= 1'b0;
    end else if (accept_s) begin
      mem_addr_r  <= bus.req_addr[ADDR_W-1:0];
      mem_type_r  <= bus.req_type;
      mem_wdata_r <= bus.req_wdata;
      cnt_r       <= CNT_LOAD;
      rsp_data_r  <= 32'd0;
      rsp_err_r   <= err_s;
    end else if (state_r == ST_READ) begin
      if (cnt_r == CNT_ZERO) begin
        rsp_data_r <= bus.memDataOut;
      end else begin
        cnt_r <= cnt_r - CNT_ONE;
      end
    end
  end

  assign bus.req_ready = req_ready_r;
  assign bus.rsp_valid = rsp_valid_r;
  assign bus.rsp_data  = rsp_data_r;
  assign bus.rsp_err   = rsp_err_r;
  assign bus.memAddr   = mem_addr_r;
  assign bus.memRead   = mem_read_r;
  assign bus.memWrite  = mem_write_r;
  assign bus.memDataIn = mem_wdata_r;
  assign bus.memType   = mem_type_r;

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Self-checking bench for lsu_mem_ctrl: byte-array memory model on the port,
// independent byte-level reference for expected load results and error decisions.
module tb_lsu_mem_ctrl;

  localparam int AW = 15;
  localparam int L  = 1;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;

  lsu_mem_ctrl_if #(.ADDR_W(AW)) bus();

  lsu_mem_ctrl #(.ADDR_W(AW), .READ_LATENCY(L)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model: writes land at the edge ending the memWrite cycle, reads return after one edge.
  logic [7:0] mem_arr [int];
  logic [31:0] rd_q;

  function automatic logic [7:0] mem_byte(input int a);
    return mem_arr.exists(a) ? mem_arr[a] : 8'h00;
  endfunction

  always @(posedge clk) begin
    int a;
    logic [31:0] w;
    a = int'(bus.memAddr);
    if (bus.memWrite) begin
      case (bus.memType)
        3'b000: mem_arr[a] = bus.memDataIn[7:0];
        3'b001: begin mem_arr[a] = bus.memDataIn[7:0]; mem_arr[a+1] = bus.memDataIn[15:8]; end
        3'b010: for (int k = 0; k < 4; k++) mem_arr[a+k] = bus.memDataIn[8*k +: 8];
        default: ;
      endcase
    end
    w = {mem_byte(a+3), mem_byte(a+2), mem_byte(a+1), mem_byte(a)};
    if (bus.memRead) begin
      case (bus.memType)
        3'b000:  rd_q <= {{24{w[7]}}, w[7:0]};
        3'b100:  rd_q <= {24'd0, w[7:0]};
        3'b001:  rd_q <= {{16{w[15]}}, w[15:0]};
        3'b101:  rd_q <= {16'd0, w[15:0]};
        default: rd_q <= w;
      endcase
    end else begin
      rd_q <= 32'hA5A5_A5A5;
    end
  end
  assign bus.memDataOut = rd_q;

  // Reference model, byte granular, built from the architectural rules.
  logic [7:0] ref_mem [int];

  function automatic int rb(input int a);
    return ref_mem.exists(a) ? int'(ref_mem[a]) : 0;
  endfunction

  function automatic logic ref_err(input logic st, input logic [2:0] ty, input logic [31:0] addr);
    logic e;
    e = 1'b0;
    if (longint'(addr) >= (longint'(1) << AW)) e = 1'b1;
    if (st && !(ty inside {3'b000, 3'b001, 3'b010})) e = 1'b1;
    if (!st && (ty inside {3'b011, 3'b110, 3'b111})) e = 1'b1;
    if ((ty == 3'b001 || ty == 3'b101) && (addr % 2 != 0)) e = 1'b1;
    if (ty == 3'b010 && (addr % 4 != 0)) e = 1'b1;
    return e;
  endfunction

  function automatic logic [31:0] ref_load(input logic [2:0] ty, input logic [31:0] addr);
    int a;
    longint v;
    a = int'(addr % 32768);
    case (ty)
      3'b000:  begin v = rb(a); if (v >= 128) v = v - 256; end
      3'b100:  v = rb(a);
      3'b001:  begin v = rb(a) + 256 * rb(a+1); if (v >= 32768) v = v - 65536; end
      3'b101:  v = rb(a) + 256 * rb(a+1);
      default: v = rb(a) + 256 * rb(a+1) + 65536 * longint'(rb(a+2)) + 16777216 * longint'(rb(a+3));
    endcase
    return v[31:0];
  endfunction

  task automatic ref_store(input logic [2:0] ty, input logic [31:0] addr, input logic [31:0] wd);
    int n;
    n = (ty == 3'b000) ? 1 : (ty == 3'b001) ? 2 : 4;
    for (int k = 0; k < n; k++) ref_mem[int'(addr % 32768) + k] = wd[8*k +: 8];
  endtask

  function automatic int exp_cycle(input logic st, input logic e);
    return e ? 1 : (st ? 2 : 2 + L);
  endfunction

  function automatic logic [31:0] exp_wr(input logic st, input logic e);
    return (!e && st) ? 32'h0000_0002 : 32'h0000_0000;
  endfunction

  function automatic logic [31:0] exp_rd(input logic st, input logic e);
    return (!e && !st) ? (((32'd1 << (L + 1)) - 32'd1) << 1) : 32'h0000_0000;
  endfunction

  typedef struct {
    int          rsp_cyc;
    logic [31:0] data;
    logic        err;
    logic [31:0] wr_mask;
    logic [31:0] rd_mask;
    logic [14:0] addr;
    logic [2:0]  typ;
    logic [31:0] din;
    int          port_changes;
    int          hold_busy;
    logic        valid_after;
    logic        ready_after;
  } obs_t;

  // Runs one request and records what the DUT did; checking is left to the caller.
  task automatic run_txn(input logic st, input logic [2:0] ty, input logic [31:0] addr,
                         input logic [31:0] wd, input int hold, input logic poke, output obs_t o);
    int w;
    o = '{default: 0};
    o.rsp_cyc = -2;
    w = 0;
    @(negedge clk);
    while (!bus.req_ready && w < 20) begin @(negedge clk); w++; end
    if (!bus.req_ready) return;
    bus.req_valid = 1'b1; bus.req_store = st; bus.req_type = ty;
    bus.req_addr = addr;  bus.req_wdata = wd;
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    o.rsp_cyc = -1;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (c < 32) begin
        if (bus.memWrite) o.wr_mask[c] = 1'b1;
        if (bus.memRead)  o.rd_mask[c] = 1'b1;
      end
      if (c == 1) begin
        o.addr = bus.memAddr; o.typ = bus.memType; o.din = bus.memDataIn;
      end else if (bus.memAddr !== o.addr || bus.memType !== o.typ || bus.memDataIn !== o.din) begin
        o.port_changes++;
      end
      if (bus.rsp_valid) begin o.rsp_cyc = c; break; end
    end
    if (o.rsp_cyc < 0) return;
    o.data = bus.rsp_data;
    o.err  = bus.rsp_err;
    if (poke) begin
      bus.req_valid = 1'b1; bus.req_store = 1'b0; bus.req_type = 3'b010;
      bus.req_addr = addr ^ 32'h0000_0040;
    end
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      if (!bus.rsp_valid || bus.rsp_data !== o.data || bus.rsp_err !== o.err || bus.memAddr !== o.addr)
        o.port_changes++;
      if (bus.req_ready || bus.memRead || bus.memWrite) o.hold_busy++;
    end
    bus.rsp_ready = 1'b1;
    @(posedge clk);
    #1 bus.rsp_ready = 1'b0;
    @(negedge clk);
    o.valid_after = bus.rsp_valid;
    o.ready_after = bus.req_ready;
    if (bus.memAddr !== o.addr) o.port_changes++;
    bus.req_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    #1 rst = 1'b1;
    #3;
    n_checks++;
    if ({bus.req_ready, bus.rsp_valid, bus.rsp_data, bus.rsp_err, bus.memRead, bus.memWrite,
         bus.memAddr, bus.memDataIn, bus.memType} !== '0) begin
      n_fail++; $display("FAIL reset_values: outputs not all zero during reset");
    end
    @(negedge clk) rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    n_checks++;
    if (bus.req_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b expected 1", bus.req_ready); end
    // Reset in the middle of a load.
    bus.req_valid = 1'b1; bus.req_store = 1'b0; bus.req_type = 3'b010;
    bus.req_addr = 32'h0000_0108; bus.req_wdata = 32'd0;
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    @(negedge clk);
    n_checks++;
    if (bus.memRead !== 1'b1) begin n_fail++; $display("FAIL reset_mid_read: memRead %b expected 1", bus.memRead); end
    #1 rst = 1'b1;
    #1;
    n_checks++;
    if ({bus.req_ready, bus.rsp_valid, bus.rsp_data, bus.rsp_err, bus.memRead, bus.memWrite,
         bus.memAddr, bus.memDataIn, bus.memType} !== '0) begin
      n_fail++; $display("FAIL reset_async: outputs not cleared immediately, memRead=%b memAddr=%h", bus.memRead, bus.memAddr);
    end
    @(negedge clk) rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    n_checks++;
    if (bus.req_ready !== 1'b1 || bus.rsp_valid !== 1'b0) begin
      n_fail++; $display("FAIL reset_release: req_ready=%b rsp_valid=%b expected 1/0", bus.req_ready, bus.rsp_valid);
    end
  endtask

  task automatic test_word();
    obs_t o;
    run_txn(1'b1, 3'b010, 32'h0000_0104, 32'hDEAD_BEEF, 0, 1'b0, o);
    ref_store(3'b010, 32'h0000_0104, 32'hDEAD_BEEF);
    n_checks++;
    if (o.wr_mask !== 32'h2 || o.rd_mask !== 32'h0) begin
      n_fail++; $display("FAIL sw_strobes: wr=%h rd=%h expected 2/0", o.wr_mask, o.rd_mask);
    end
    n_checks++;
    if (o.addr !== 15'h104 || o.typ !== 3'b010 || o.din !== 32'hDEAD_BEEF) begin
      n_fail++; $display("FAIL sw_port: addr=%h type=%b din=%h", o.addr, o.typ, o.din);
    end
    n_checks++;
    if (o.rsp_cyc !== 2 || o.err !== 1'b0 || o.data !== 32'd0) begin
      n_fail++; $display("FAIL sw_rsp: cycle=%0d err=%b data=%h expected 2/0/0", o.rsp_cyc, o.err, o.data);
    end
    run_txn(1'b0, 3'b010, 32'h0000_0104, 32'd0, 0, 1'b0, o);
    n_checks++;
    if (o.rd_mask !== 32'h6 || o.wr_mask !== 32'h0) begin
      n_fail++; $display("FAIL lw_strobes: rd=%h wr=%h expected 6/0", o.rd_mask, o.wr_mask);
    end
    n_checks++;
    if (o.rsp_cyc !== 3 || o.err !== 1'b0 || o.data !== 32'hDEAD_BEEF) begin
      n_fail++; $display("FAIL lw_rsp: cycle=%0d err=%b data=%h expected 3/0/deadbeef", o.rsp_cyc, o.err, o.data);
    end
  endtask

  task automatic test_byte_ext();
    obs_t o;
    run_txn(1'b1, 3'b000, 32'h0000_0103, 32'h0000_0080, 0, 1'b0, o);
    ref_store(3'b000, 32'h0000_0103, 32'h0000_0080);
    run_txn(1'b0, 3'b000, 32'h0000_0103, 32'd0, 0, 1'b0, o);
    n_checks++;
    if (o.data !== 32'hFFFF_FF80) begin n_fail++; $display("FAIL lb_sign: got %h expected ffffff80", o.data); end
    run_txn(1'b0, 3'b100, 32'h0000_0103, 32'd0, 0, 1'b0, o);
    n_checks++;
    if (o.data !== 32'h0000_0080) begin n_fail++; $display("FAIL lbu_zero: got %h expected 00000080", o.data); end
    run_txn(1'b0, 3'b001, 32'h0000_0102, 32'd0, 1, 1'b0, o);
    n_checks++;
    if (o.data !== ref_load(3'b001, 32'h0000_0102)) begin
      n_fail++; $display("FAIL lh_sign: got %h expected %h", o.data, ref_load(3'b001, 32'h0000_0102));
    end
  endtask

  task automatic test_errors();
    obs_t o;
    logic        st [4]  = '{1'b0, 1'b0, 1'b1, 1'b0};
    logic [2:0]  ty [4]  = '{3'b001, 3'b010, 3'b100, 3'b010};
    logic [31:0] ad [4]  = '{32'h0000_0101, 32'h0000_0106, 32'h0000_0104, 32'h0000_8000};
    for (int i = 0; i < 4; i++) begin
      run_txn(st[i], ty[i], ad[i], 32'h1234_5678, i, 1'b0, o);
      n_checks++;
      if (o.err !== 1'b1 || o.data !== 32'd0) begin
        n_fail++; $display("FAIL err_rsp[%0d]: err=%b data=%h expected 1/0", i, o.err, o.data);
      end
      n_checks++;
      if ((o.wr_mask | o.rd_mask) !== 32'd0 || o.rsp_cyc !== 1) begin
        n_fail++; $display("FAIL err_timing[%0d]: strobes=%h cycle=%0d expected 0/1", i, o.wr_mask | o.rd_mask, o.rsp_cyc);
      end
    end
  endtask

  task automatic test_backpressure();
    obs_t o;
    run_txn(1'b0, 3'b010, 32'h0000_0104, 32'd0, 5, 1'b1, o);
    n_checks++;
    if (o.port_changes !== 0 || o.hold_busy !== 0) begin
      n_fail++; $display("FAIL bp_stable: changes=%0d busy=%0d expected 0/0", o.port_changes, o.hold_busy);
    end
    n_checks++;
    if (o.data !== ref_load(3'b010, 32'h0000_0104)) begin
      n_fail++; $display("FAIL bp_data: got %h expected %h", o.data, ref_load(3'b010, 32'h0000_0104));
    end
    n_checks++;
    if (o.valid_after !== 1'b0 || o.ready_after !== 1'b1) begin
      n_fail++; $display("FAIL bp_release: rsp_valid=%b req_ready=%b expected 0/1", o.valid_after, o.ready_after);
    end
  endtask

  task automatic test_reset_during_write();
    obs_t o;
    run_txn(1'b1, 3'b010, 32'h0000_0120, 32'h1122_3344, 0, 1'b0, o);
    ref_store(3'b010, 32'h0000_0120, 32'h1122_3344);
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_store = 1'b1; bus.req_type = 3'b010;
    bus.req_addr = 32'h0000_0120; bus.req_wdata = 32'hCAFE_F00D;
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    @(negedge clk);
    n_checks++;
    if (bus.memWrite !== 1'b1) begin n_fail++; $display("FAIL rstw_write: memWrite %b expected 1", bus.memWrite); end
    #1 rst = 1'b1;
    #1;
    n_checks++;
    if (bus.memWrite !== 1'b0 || bus.rsp_valid !== 1'b0) begin
      n_fail++; $display("FAIL rstw_drop: memWrite=%b rsp_valid=%b expected 0/0", bus.memWrite, bus.rsp_valid);
    end
    @(negedge clk) rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    n_checks++;
    if (bus.req_ready !== 1'b1) begin n_fail++; $display("FAIL rstw_idle: req_ready %b expected 1", bus.req_ready); end
    run_txn(1'b0, 3'b010, 32'h0000_0120, 32'd0, 0, 1'b0, o);
    n_checks++;
    if (o.data !== 32'h1122_3344) begin n_fail++; $display("FAIL rstw_readback: got %h expected 11223344", o.data); end
  endtask

  task automatic test_back_to_back();
    obs_t o;
    int acc [4];
    logic [31:0] wd [4];
    int n;
    int cyc;
    for (int i = 0; i < 4; i++) wd[i] = $urandom;
    n = 0;
    cyc = 0;
    @(negedge clk);
    bus.rsp_ready = 1'b1;
    bus.req_valid = 1'b1; bus.req_store = 1'b1; bus.req_type = 3'b010;
    bus.req_addr = 32'h0000_0130; bus.req_wdata = wd[0];
    while (n < 4 && cyc < 40) begin
      if (bus.req_ready) begin
        acc[n] = cyc;
        ref_store(3'b010, 32'h0000_0130 + 32'(4 * n), wd[n]);
        n++;
        @(posedge clk);
        #1;
        if (n < 4) begin bus.req_addr = 32'h0000_0130 + 32'(4 * n); bus.req_wdata = wd[n]; end
        else bus.req_valid = 1'b0;
      end
      @(negedge clk);
      cyc++;
    end
    bus.req_valid = 1'b0;
    for (int k = 0; k < 10 && !bus.req_ready; k++) @(negedge clk);
    bus.rsp_ready = 1'b0;
    n_checks++;
    if (n !== 4) begin n_fail++; $display("FAIL b2b_count: accepted %0d expected 4", n); end
    for (int i = 0; i + 1 < n; i++) begin
      n_checks++;
      if (acc[i+1] - acc[i] !== 3) begin
        n_fail++; $display("FAIL b2b_spacing[%0d]: %0d cycles expected 3", i, acc[i+1] - acc[i]);
      end
    end
    for (int i = 0; i < 4; i++) begin
      run_txn(1'b0, 3'b010, 32'h0000_0130 + 32'(4 * i), 32'd0, 0, 1'b0, o);
      n_checks++;
      if (o.data !== wd[i]) begin n_fail++; $display("FAIL b2b_readback[%0d]: got %h expected %h", i, o.data, wd[i]); end
    end
  endtask

  task automatic test_random();
    obs_t o;
    logic st;
    logic [2:0] ty;
    logic [31:0] addr;
    logic [31:0] wd;
    logic e;
    logic [31:0] exp_d;
    int hold;
    for (int i = 0; i < 60; i++) begin
      st = 1'($urandom_range(0, 1));
      ty = 3'($urandom_range(0, 7));
      if (st && $urandom_range(0, 2) != 0) ty = 3'($urandom_range(0, 2));
      addr = 32'h0000_0100 + 32'($urandom_range(0, 63));
      if ($urandom_range(0, 9) == 0) addr = addr | (32'd1 << $urandom_range(15, 31));
      wd = $urandom;
      hold = $urandom_range(0, 3);
      e = ref_err(st, ty, addr);
      exp_d = (e || st) ? 32'd0 : ref_load(ty, addr);
      run_txn(st, ty, addr, wd, hold, 1'b0, o);
      if (!e && st) ref_store(ty, addr, wd);
      n_checks++;
      if (o.rsp_cyc !== exp_cycle(st, e) || o.err !== e) begin
        n_fail++; $display("FAIL rnd_rsp[%0d]: cycle=%0d err=%b expected %0d/%b", i, o.rsp_cyc, o.err, exp_cycle(st, e), e);
      end
      n_checks++;
      if (o.data !== exp_d) begin n_fail++; $display("FAIL rnd_data[%0d]: got %h expected %h", i, o.data, exp_d); end
      n_checks++;
      if (o.wr_mask !== exp_wr(st, e) || o.rd_mask !== exp_rd(st, e)) begin
        n_fail++; $display("FAIL rnd_strobes[%0d]: wr=%h rd=%h expected %h/%h", i, o.wr_mask, o.rd_mask, exp_wr(st, e), exp_rd(st, e));
      end
      n_checks++;
      if (o.addr !== addr[14:0] || o.typ !== ty || o.din !== wd) begin
        n_fail++; $display("FAIL rnd_port[%0d]: addr=%h type=%b din=%h", i, o.addr, o.typ, o.din);
      end
      n_checks++;
      if (o.port_changes !== 0 || o.hold_busy !== 0 || o.valid_after !== 1'b0 || o.ready_after !== 1'b1) begin
        n_fail++; $display("FAIL rnd_protocol[%0d]: changes=%0d busy=%0d valid_after=%b ready_after=%b",
                           i, o.port_changes, o.hold_busy, o.valid_after, o.ready_after);
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_checks = 0;
    n_fail   = 0;
    bus.req_valid = 1'b0;
    bus.req_store = 1'b0;
    bus.req_type  = 3'b000;
    bus.req_addr  = 32'd0;
    bus.req_wdata = 32'd0;
    bus.rsp_ready = 1'b0;
    test_reset();
    test_word();
    test_byte_ext();
    test_errors();
    test_backpressure();
    test_reset_during_write();
    test_back_to_back();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
